// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop command front-end for one attached `stack` block.
// TOS lives in a local register; the stack memory holds everything below it
// and its registered Q presents next-of-stack. A one-cycle SETTLE state
// follows every stack write so that Q has recovered from read-during-write
// before the next command is accepted.
module stack_ctrl #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [width-1:0]     cmd_data,
    output logic [width-1:0]     tos,
    output logic [width-1:0]     nos,
    output logic                 nos_valid,
    output logic [saddr_width:0] depth,
    output logic                 empty,
    output logic                 full,
    output logic                 err_overflow,
    output logic                 err_underflow,
    input  logic                 err_clr,
    output logic [width-1:0]     stk_D,
    output logic                 stk_dec,
    output logic                 stk_change,
    output logic                 stk_update,
    input  logic [width-1:0]     stk_Q
);

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_SET_TOS = 2'b10;

    localparam logic [saddr_width:0] DEPTH_ONE = (saddr_width + 1)'(1);
    localparam logic [saddr_width:0] DEPTH_TWO = (saddr_width + 1)'(2);
    localparam logic [saddr_width:0] MAX_DEPTH = {1'b1, {saddr_width{1'b0}}};

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     tos_q, tos_d;
    logic [saddr_width:0] depth_q, depth_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 ready_q, ready_d;
    logic                 nos_valid_q, nos_valid_d;
    logic                 accept;
    logic                 is_full;

    assign accept  = cmd_valid && (state_q == IDLE);
    assign is_full = (depth_q == MAX_DEPTH);

    // Decode the accepted command into next state and the stack strobes.
    always_comb begin
        state_d    = IDLE;
        tos_d      = tos_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q & ~err_clr;
        unf_d      = unf_q & ~err_clr;
        stk_D      = tos_q;
        stk_change = 1'b0;
        stk_dec    = 1'b0;
        stk_update = 1'b0;
        if (accept) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else if (depth_q == '0) begin
                        // First entry lives only in the TOS register.
                        tos_d   = cmd_data;
                        depth_d = DEPTH_ONE;
                    end else begin
                        // Spill the old TOS into memory at SP+1.
                        stk_change = 1'b1;
                        tos_d      = cmd_data;
                        depth_d    = depth_q + DEPTH_ONE;
                        state_d    = SETTLE;
                    end
                end
                OP_POP: begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else if (depth_q == DEPTH_ONE) begin
                        tos_d   = '0;
                        depth_d = '0;
                    end else begin
                        // No write involved, so Q reloads cleanly on this edge.
                        stk_change = 1'b1;
                        stk_dec    = 1'b1;
                        tos_d      = stk_Q;
                        depth_d    = depth_q - DEPTH_ONE;
                    end
                end
                OP_SET_TOS: begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d = cmd_data;
                    end
                end
                default: begin
                    if (depth_q < DEPTH_TWO) begin
                        unf_d = 1'b1;
                    end else begin
                        stk_update = 1'b1;
                        stk_D      = cmd_data;
                        state_d    = SETTLE;
                    end
                end
            endcase
        end
        ready_d     = (state_d == IDLE);
        nos_valid_d = (state_d == IDLE) && (depth_d >= DEPTH_TWO);
    end

    // FSM and all registered state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tos_q       <= '0;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ready_q     <= 1'b1;
            nos_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ready_q     <= ready_d;
            nos_valid_q <= nos_valid_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign tos           = tos_q;
    assign nos           = stk_Q;
    assign nos_valid     = nos_valid_q;
    assign depth         = depth_q;
    assign empty         = (depth_q == '0);
    assign full          = is_full;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: instance 0 uses the default 8-bit stack address,
// instance 1 a 2-bit address so that the full boundary is easy to reach.
// Each instance is attached to a small behavioural model of the stack block.
module tb_stack_ctrl;

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_SET_TOS = 2'b10;
    localparam logic [1:0] OP_SET_NOS = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid [2];
    logic [1:0]  cmd_op [2];
    logic [15:0] cmd_data [2];
    logic        err_clr [2];
    logic        cmd_ready [2];
    logic [15:0] tos [2];
    logic [15:0] nos [2];
    logic        nos_valid [2];
    logic [8:0]  depth_w [2];
    logic        empty [2];
    logic        full [2];
    logic        err_ov [2];
    logic        err_un [2];
    logic [15:0] stk_d_w [2];
    logic        stk_dec [2];
    logic        stk_change [2];
    logic        stk_update [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an array used as a stack, index depth-1 is the top.
    logic [15:0] marr [2][256];
    int          mdepth [2];
    bit          mov [2];
    bit          mun [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int SW = (gi == 0) ? 8 : 2;
        logic [SW:0]   depth_n;
        logic [15:0]   stk_q;
        logic [15:0]   smem [1 << SW];
        logic [SW-1:0] sp;
        logic [SW-1:0] sp_inc;
        logic [SW-1:0] sp_dec;

        stack_ctrl #(.saddr_width(SW), .width(16)) u_dut (
            .clk          (clk),
            .reset_n      (rst_n),
            .cmd_valid    (cmd_valid[gi]),
            .cmd_ready    (cmd_ready[gi]),
            .cmd_op       (cmd_op[gi]),
            .cmd_data     (cmd_data[gi]),
            .tos          (tos[gi]),
            .nos          (nos[gi]),
            .nos_valid    (nos_valid[gi]),
            .depth        (depth_n),
            .empty        (empty[gi]),
            .full         (full[gi]),
            .err_overflow (err_ov[gi]),
            .err_underflow(err_un[gi]),
            .err_clr      (err_clr[gi]),
            .stk_D        (stk_d_w[gi]),
            .stk_dec      (stk_dec[gi]),
            .stk_change   (stk_change[gi]),
            .stk_update   (stk_update[gi]),
            .stk_Q        (stk_q)
        );

        assign depth_w[gi] = 9'(depth_n);
        assign sp_inc      = sp + SW'(1);
        assign sp_dec      = sp - SW'(1);

        // Stack block model: SP-addressed memory, Q registered, old data on read-during-write.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sp    <= '0;
                stk_q <= '0;
            end else if (stk_change[gi] && !stk_dec[gi]) begin
                smem[sp_inc] <= stk_d_w[gi];
                sp           <= sp_inc;
                stk_q        <= smem[sp_inc];
            end else if (stk_change[gi] && stk_dec[gi]) begin
                sp    <= sp_dec;
                stk_q <= smem[sp_dec];
            end else if (stk_update[gi]) begin
                smem[sp] <= stk_d_w[gi];
                stk_q    <= smem[sp];
            end else begin
                stk_q <= smem[sp];
            end
        end
    end

    function automatic logic [15:0] m_tos(input int i);
        return (mdepth[i] > 0) ? marr[i][mdepth[i]-1] : 16'h0000;
    endfunction

    function automatic logic [15:0] m_nos(input int i);
        return (mdepth[i] > 1) ? marr[i][mdepth[i]-2] : 16'h0000;
    endfunction

    function automatic int m_cap(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mdepth[i] = 0;
            mov[i]    = 1'b0;
            mun[i]    = 1'b0;
        end
    endtask

    // Apply one accepted command to the model; returns the expected strobes.
    task automatic model_cmd(input int i, input logic [1:0] op, input logic [15:0] d, input bit clr,
                             output bit e_chg, output bit e_dec, output bit e_upd,
                             output logic [15:0] e_stkd, output bit e_settle);
        bit nov;
        bit nun;
        nov = 1'b0;
        nun = 1'b0;
        e_chg = 1'b0;
        e_dec = 1'b0;
        e_upd = 1'b0;
        e_settle = 1'b0;
        e_stkd = (op == OP_SET_NOS && mdepth[i] >= 2) ? d : m_tos(i);
        case (op)
            OP_PUSH: begin
                if (mdepth[i] == m_cap(i)) nov = 1'b1;
                else begin
                    if (mdepth[i] > 0) begin
                        e_chg = 1'b1;
                        e_settle = 1'b1;
                    end
                    marr[i][mdepth[i]] = d;
                    mdepth[i]++;
                end
            end
            OP_POP: begin
                if (mdepth[i] == 0) nun = 1'b1;
                else begin
                    if (mdepth[i] >= 2) begin
                        e_chg = 1'b1;
                        e_dec = 1'b1;
                    end
                    mdepth[i]--;
                end
            end
            OP_SET_TOS: begin
                if (mdepth[i] == 0) nun = 1'b1;
                else marr[i][mdepth[i]-1] = d;
            end
            default: begin
                if (mdepth[i] < 2) nun = 1'b1;
                else begin
                    e_upd = 1'b1;
                    e_settle = 1'b1;
                    marr[i][mdepth[i]-2] = d;
                end
            end
        endcase
        mov[i] = (mov[i] & !clr) | nov;
        mun[i] = (mun[i] & !clr) | nun;
    endtask

    // Drive one command at a falling edge; strobes sampled before the rising edge,
    // o_settle sampled at the next falling edge.
    task automatic drive_cmd(input int i, input logic [1:0] op, input logic [15:0] d, input bit clr,
                             output bit o_chg, output bit o_dec, output bit o_upd,
                             output logic [15:0] o_stkd, output bit o_settle);
        for (int k = 0; k < 4 && !cmd_ready[i]; k++) @(negedge clk);
        n_tests++;
        if (cmd_ready[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait inst=%0d cmd_ready=%b required=1", i, cmd_ready[i]);
        end
        cmd_valid[i] = 1'b1;
        cmd_op[i]    = op;
        cmd_data[i]  = d;
        err_clr[i]   = clr;
        #1;
        o_chg  = stk_change[i];
        o_dec  = stk_dec[i];
        o_upd  = stk_update[i];
        o_stkd = stk_d_w[i];
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        err_clr[i]   = 1'b0;
        o_settle     = !cmd_ready[i];
    endtask

    task automatic clr_pulse(input int i);
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
        mov[i] = 1'b0;
        mun[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({tos[i], depth_w[i], empty[i], full[i], err_ov[i], err_un[i], nos_valid[i]} !==
                {16'h0, 9'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d tos=%h depth=%0d empty=%b full=%b ov=%b un=%b nv=%b required 0/0/1/0/0/0/0",
                         i, tos[i], depth_w[i], empty[i], full[i], err_ov[i], err_un[i], nos_valid[i]);
            end
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({cmd_ready[i], stk_change[i], stk_dec[i], stk_update[i]} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_ctrl inst=%0d ready=%b chg=%b dec=%b upd=%b required 1/0/0/0",
                         i, cmd_ready[i], stk_change[i], stk_dec[i], stk_update[i]);
            end
        end
    endtask

    task automatic test_push();
        logic [15:0] vals [3];
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd;
        vals = '{16'h1111, 16'h2222, 16'h3333};
        for (int k = 0; k < 3; k++) begin
            model_cmd(0, OP_PUSH, vals[k], 1'b0, ec, ed, eu, esd, es);
            drive_cmd(0, OP_PUSH, vals[k], 1'b0, c, dd, u, sd, s);
            n_tests++;
            if ({s, c, sd} !== {(k > 0), (k > 0), vals[(k > 0) ? k - 1 : 0]} && k > 0 || (k == 0 && {s, c} !== 2'b00)) begin
                n_fail++;
                $display("FAIL push_seq k=%0d settle=%b chg=%b stkD=%h required settle=%0d chg=%0d", k, s, c, sd, k > 0, k > 0);
            end
            if (s) begin
                @(negedge clk);
                n_tests++;
                if (cmd_ready[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL push_settle_len k=%0d cmd_ready=%b required=1", k, cmd_ready[0]);
                end
            end
        end
        n_tests++;
        if ({tos[0], depth_w[0], nos[0], nos_valid[0]} !== {16'h3333, 9'd3, 16'h2222, 1'b1}) begin
            n_fail++;
            $display("FAIL push_result tos=%h depth=%0d nos=%h nv=%b required 3333/3/2222/1",
                     tos[0], depth_w[0], nos[0], nos_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_tos [3];
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd;
        exp_tos = '{16'h2222, 16'h1111, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            model_cmd(0, OP_POP, 16'h0, 1'b0, ec, ed, eu, esd, es);
            drive_cmd(0, OP_POP, 16'h0, 1'b0, c, dd, u, sd, s);
            n_tests++;
            if ({c, dd, u, s, tos[0], depth_w[0]} !== {(k < 2), (k < 2), 1'b0, 1'b0, exp_tos[k], 9'(2 - k)}) begin
                n_fail++;
                $display("FAIL b2b_pop k=%0d chg=%b dec=%b upd=%b settle=%b tos=%h depth=%0d required chg=dec=%0d tos=%h depth=%0d",
                         k, c, dd, u, s, tos[0], depth_w[0], k < 2, exp_tos[k], 2 - k);
            end
        end
    endtask

    task automatic test_underflow();
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd;
        model_cmd(0, OP_POP, 16'h0, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_POP, 16'h0, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if ({err_un[0], tos[0], depth_w[0], c} !== {1'b1, 16'h0, 9'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_empty un=%b tos=%h depth=%0d chg=%b required 1/0000/0/0", err_un[0], tos[0], depth_w[0], c);
        end
        clr_pulse(0);
        n_tests++;
        if (err_un[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_underflow un=%b required=0", err_un[0]);
        end
        model_cmd(0, OP_PUSH, 16'h0055, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_PUSH, 16'h0055, 1'b0, c, dd, u, sd, s);
        model_cmd(0, OP_SET_NOS, 16'h0077, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_SET_NOS, 16'h0077, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if ({err_un[0], tos[0], depth_w[0], u, s} !== {1'b1, 16'h0055, 9'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL setnos_shallow un=%b tos=%h depth=%0d upd=%b settle=%b required 1/0055/1/0/0",
                     err_un[0], tos[0], depth_w[0], u, s);
        end
        clr_pulse(0);
        model_cmd(0, OP_SET_NOS, 16'h0088, 1'b1, ec, ed, eu, esd, es);
        drive_cmd(0, OP_SET_NOS, 16'h0088, 1'b1, c, dd, u, sd, s);
        n_tests++;
        if (err_un[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_set un=%b required=1", err_un[0]);
        end
        clr_pulse(0);
        model_cmd(0, OP_POP, 16'h0, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_POP, 16'h0, 1'b0, c, dd, u, sd, s);
    endtask

    task automatic test_overflow();
        logic [15:0] vals [4];
        logic [15:0] extra;
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd;
        for (int k = 0; k < 4; k++) begin
            vals[k] = 16'($urandom);
            model_cmd(1, OP_PUSH, vals[k], 1'b0, ec, ed, eu, esd, es);
            drive_cmd(1, OP_PUSH, vals[k], 1'b0, c, dd, u, sd, s);
        end
        @(negedge clk);
        n_tests++;
        if ({depth_w[1], full[1], err_ov[1]} !== {9'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fill depth=%0d full=%b ov=%b required 4/1/0", depth_w[1], full[1], err_ov[1]);
        end
        extra = 16'($urandom);
        model_cmd(1, OP_PUSH, extra, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(1, OP_PUSH, extra, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if ({err_ov[1], depth_w[1], tos[1], c, s} !== {1'b1, 9'd4, vals[3], 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL push_full ov=%b depth=%0d tos=%h chg=%b settle=%b required 1/4/%h/0/0",
                     err_ov[1], depth_w[1], tos[1], c, s, vals[3]);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (tos[1] !== vals[3 - k]) begin
                n_fail++;
                $display("FAIL lifo k=%0d tos=%h required=%h", k, tos[1], vals[3 - k]);
            end
            model_cmd(1, OP_POP, 16'h0, 1'b0, ec, ed, eu, esd, es);
            drive_cmd(1, OP_POP, 16'h0, 1'b0, c, dd, u, sd, s);
        end
        n_tests++;
        if ({depth_w[1], empty[1]} !== {9'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL drain depth=%0d empty=%b required 0/1", depth_w[1], empty[1]);
        end
        clr_pulse(1);
    endtask

    task automatic test_set_nos();
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd, v;
        for (int k = 0; k < 3; k++) begin
            v = 16'($urandom);
            model_cmd(0, OP_PUSH, v, 1'b0, ec, ed, eu, esd, es);
            drive_cmd(0, OP_PUSH, v, 1'b0, c, dd, u, sd, s);
        end
        model_cmd(0, OP_SET_NOS, 16'hBEEF, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_SET_NOS, 16'hBEEF, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if ({u, c, dd, sd, s} !== {1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL setnos_strobe upd=%b chg=%b dec=%b stkD=%h settle=%b required 1/0/0/beef/1", u, c, dd, sd, s);
        end
        n_tests++;
        if ({stk_update[0], nos_valid[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL setnos_settle upd=%b nv=%b required 0/0", stk_update[0], nos_valid[0]);
        end
        @(negedge clk);
        n_tests++;
        if ({nos[0], nos_valid[0], cmd_ready[0]} !== {16'hBEEF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL setnos_result nos=%h nv=%b ready=%b required beef/1/1", nos[0], nos_valid[0], cmd_ready[0]);
        end
        model_cmd(0, OP_SET_TOS, 16'h0042, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_SET_TOS, 16'h0042, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if ({c, dd, u, s, tos[0], nos[0], depth_w[0]} !== {4'b0000, 16'h0042, 16'hBEEF, 9'd3}) begin
            n_fail++;
            $display("FAIL settos chg=%b dec=%b upd=%b settle=%b tos=%h nos=%h depth=%0d required 0/0/0/0/0042/beef/3",
                     c, dd, u, s, tos[0], nos[0], depth_w[0]);
        end
    endtask

    task automatic test_reset_settle();
        bit c, dd, u, s, ec, ed, eu, es;
        logic [15:0] sd, esd;
        model_cmd(1, OP_POP, 16'h0, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(1, OP_POP, 16'h0, 1'b0, c, dd, u, sd, s);
        model_cmd(0, OP_PUSH, 16'h5A5A, 1'b0, ec, ed, eu, esd, es);
        drive_cmd(0, OP_PUSH, 16'h5A5A, 1'b0, c, dd, u, sd, s);
        n_tests++;
        if (s !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_settle settle=%b required=1", s);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tos[0], depth_w[0], err_ov[0], err_un[0], err_un[1]} !== {16'h0, 9'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset tos=%h depth=%0d ov=%b un0=%b un1=%b required 0/0/0/0/0",
                     tos[0], depth_w[0], err_ov[0], err_un[0], err_un[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({cmd_ready[0], cmd_ready[1], depth_w[0]} !== {2'b11, 9'd0}) begin
            n_fail++;
            $display("FAIL post_reset ready0=%b ready1=%b depth=%0d required 1/1/0", cmd_ready[0], cmd_ready[1], depth_w[0]);
        end
    endtask

    task automatic test_random(input int i, input int n);
        bit c, dd, u, s, ec, ed, eu, es, clr;
        logic [15:0] sd, esd, d;
        logic [1:0] op;
        int r;
        for (int k = 0; k < n; k++) begin
            r   = int'($urandom_range(0, 9));
            op  = (r < 4 || r == 9) ? OP_PUSH : (r < 7) ? OP_POP : (r == 7) ? OP_SET_TOS : OP_SET_NOS;
            d   = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            model_cmd(i, op, d, clr, ec, ed, eu, esd, es);
            drive_cmd(i, op, d, clr, c, dd, u, sd, s);
            n_tests++;
            if ({c, dd, u, sd} !== {ec, ed, eu, esd}) begin
                n_fail++;
                $display("FAIL rnd_strobe inst=%0d k=%0d op=%0d chg=%b dec=%b upd=%b stkD=%h required %b/%b/%b/%h",
                         i, k, op, c, dd, u, sd, ec, ed, eu, esd);
            end
            n_tests++;
            if ({tos[i], depth_w[i], empty[i], full[i], err_ov[i], err_un[i], s} !==
                {m_tos(i), 9'(mdepth[i]), mdepth[i] == 0, mdepth[i] == m_cap(i), mov[i], mun[i], es}) begin
                n_fail++;
                $display("FAIL rnd_state inst=%0d k=%0d op=%0d tos=%h depth=%0d e=%b f=%b ov=%b un=%b settle=%b required %h/%0d/%0d/%0d/%b/%b/%b",
                         i, k, op, tos[i], depth_w[i], empty[i], full[i], err_ov[i], err_un[i], s,
                         m_tos(i), mdepth[i], mdepth[i] == 0, mdepth[i] == m_cap(i), mov[i], mun[i], es);
            end
            if (s) @(negedge clk);
            n_tests++;
            if (nos_valid[i] !== (mdepth[i] >= 2) || (mdepth[i] >= 2 && nos[i] !== m_nos(i))) begin
                n_fail++;
                $display("FAIL rnd_nos inst=%0d k=%0d nos=%h nv=%b required %h/%0d", i, k, nos[i], nos_valid[i],
                         m_nos(i), mdepth[i] >= 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_op[i]    = 2'b00;
            cmd_data[i]  = 16'h0;
            err_clr[i]   = 1'b0;
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_push();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_set_nos();
        test_reset_settle();
        test_random(1, 400);
        test_random(0, 300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
